irq_pending_latch: RTL and testbench

//  Upstream stage of priority_n in the interrupt path. Edge-detects WIDTH request lines, holds them
//  as sticky pending bits, masks them and drives py into priority_n. Takes the encoded winner
//  (pa, 0 = none, k = bit k-1) back in, then runs a valid/ready + ack service handshake to the host.

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_edge_sync.sv | 52 +++++
 rtl/priority_n.sv | 19 +
 rtl/irq_pending_latch.sv | 102 ++++++++++
 tb/tb_irq_pending_latch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt path (irq_pending_latch, priority_n).
package irq_pkg;

  localparam int unsigned IDX_NONE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

  // Encoded index width: 0 means "none", k means line k-1.
  function automatic int unsigned idx_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-line rising-edge detector with optional 2-flop synchroniser (IRQ_SYNC_EN).
module irq_edge_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq_in,
  output logic [WIDTH-1:0] edge_c
);

  logic [WIDTH-1:0] irq_s;
  logic [WIDTH-1:0] irq_q;
  logic [WIDTH-1:0] irq_d;

`ifdef IRQ_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync1_d;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] sync2_d;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // History resets low so a line held high through reset yields one edge afterwards.
  always_comb begin
    irq_d  = irq_s;
    edge_c = irq_s & ~irq_q;
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= '0;
    else     irq_q <= irq_d;
  end

endmodule

// File: rtl/priority_n.sv
// Highest-line-wins priority encoder; pa = 0 when no line is set, else bit index + 1.
module priority_n
  import irq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] py,
  output logic [IDX_W-1:0] pa
);

  always_comb begin
    pa = IDX_W'(IDX_NONE);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (py[i]) pa = IDX_W'(i + 1);
    end
  end

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending/overflow latch for interrupt lines plus one-outstanding host handshake.
// Optional input synchroniser enabled by defining IRQ_SYNC_EN.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq_in,
  input  logic [WIDTH-1:0] mask,
  input  logic [IDX_W-1:0] enc_idx,
  input  logic             irq_ready,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] py,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  output logic [WIDTH-1:0] overflow
);

  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] overflow_q, overflow_d;
  irq_state_e       state_q, state_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             irq_valid_q, irq_valid_d;

  irq_edge_sync #(.WIDTH(WIDTH)) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .edge_c (edge_c)
  );

  // Out-of-range ack indices (0 or > WIDTH) decode to no clear.
  always_comb begin
    clr_vec = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ack_valid && (32'(ack_idx) == i + 1)) clr_vec[i] = 1'b1;
    end
  end

  // A same-cycle set beats a clear and does not count as an overflow.
  always_comb begin
    pending_d  = (pending_q & ~clr_vec) | edge_c;
    overflow_d = (ovf_clr ? '0 : overflow_q) | (edge_c & pending_q & ~clr_vec);
  end

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    irq_valid_d = irq_valid_q;
    case (state_q)
      IDLE: begin
        if (enc_idx != IDX_W'(IDX_NONE)) begin
          state_d     = REQ;
          cur_idx_d   = enc_idx;
          irq_valid_d = 1'b1;
        end
      end
      REQ: begin
        if (irq_ready) begin
          state_d     = SVC;
          irq_valid_d = 1'b0;
        end
      end
      SVC: begin
        if (ack_valid && (ack_idx == cur_idx_q)) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        irq_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      overflow_q  <= '0;
      state_q     <= IDLE;
      cur_idx_q   <= '0;
      irq_valid_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      irq_valid_q <= irq_valid_d;
    end
  end

  assign py        = pending_q & ~mask;
  assign irq_valid = irq_valid_q;
  assign irq_idx   = cur_idx_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Randomised + directed bench for irq_pending_latch beside priority_n, checked against a behavioural model.
module tb_irq_pending_latch;
  import irq_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = idx_w(W);
`ifdef IRQ_SYNC_EN
  localparam int unsigned LAT = 4;
`else
  localparam int unsigned LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  irq_in = '0;
  logic [W-1:0]  mask = '0;
  logic [IW-1:0] enc_idx;
  logic          irq_ready = 1'b0;
  logic          ack_valid = 1'b0;
  logic [IW-1:0] ack_idx = '0;
  logic          ovf_clr = 1'b0;
  logic [W-1:0]  py;
  logic          irq_valid;
  logic [IW-1:0] irq_idx;
  logic [W-1:0]  overflow;

  always #5 clk = ~clk;

  irq_pending_latch #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .enc_idx(enc_idx),
    .irq_ready(irq_ready), .ack_valid(ack_valid), .ack_idx(ack_idx), .ovf_clr(ovf_clr),
    .py(py), .irq_valid(irq_valid), .irq_idx(irq_idx), .overflow(overflow)
  );

  priority_n #(.WIDTH(W)) u_prio (.py(py), .pa(enc_idx));

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: phase 0 = nothing outstanding, 1 = offered to host, 2 = host servicing.
  logic [W-1:0] m_pend = '0, m_ovf = '0, m_prev = '0, m_d0 = '0, m_d1 = '0;
  int unsigned  m_phase = 0, m_idx = 0;
  bit           live = 1'b0;

  function automatic int unsigned top_idx(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0] s, rise, clr;
    int unsigned  win;
    live <= 1'b1;
    if (rst) begin
      m_pend <= '0; m_ovf <= '0; m_prev <= '0; m_d0 <= '0; m_d1 <= '0;
      m_phase <= 0; m_idx <= 0;
    end else begin
`ifdef IRQ_SYNC_EN
      s = m_d1;
`else
      s = irq_in;
`endif
      rise = s & ~m_prev;
      clr  = '0;
      if (ack_valid && ack_idx >= 1 && ack_idx <= W) clr[int'(ack_idx) - 1] = 1'b1;
      win  = top_idx(m_pend & ~mask);
      m_d0   <= irq_in;
      m_d1   <= m_d0;
      m_prev <= s;
      m_ovf  <= (ovf_clr ? '0 : m_ovf) | (rise & m_pend & ~clr);
      m_pend <= (m_pend & ~clr) | rise;
      case (m_phase)
        0: if (win != 0) begin m_phase <= 1; m_idx <= win; end
        1: if (irq_ready) m_phase <= 2;
        default: if (ack_valid && int'(ack_idx) == m_idx) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    if (live) begin
      chk("py", py, m_pend & ~mask);
      chk("irq_valid", irq_valid, (m_phase == 1) ? 1 : 0);
      if (m_phase == 1) chk("irq_idx", irq_idx, m_idx);
      chk("overflow", overflow, m_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    do begin
      tick(1); n++;
      @(negedge clk);
    end while (!irq_valid && n < 10);
    if (!irq_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic serve(input int unsigned idx);
    irq_ready = 1'b1; tick(1); irq_ready = 1'b0;
    ack_valid = 1'b1; ack_idx = IW'(idx); tick(1); ack_valid = 1'b0; ack_idx = '0;
  endtask

  initial begin
    int unsigned n, py_n;

    // Reset
    rst = 1'b1; tick(3);
    @(negedge clk);
    chk("rst_py", py, 8'h00);
    chk("rst_valid", irq_valid, 0);
    chk("rst_ovf", overflow, 8'h00);
    rst = 1'b0; tick(1);

    // Single line with latency measurement
    irq_in = 8'h04;
    n = 0; py_n = 0;
    do begin
      tick(1); n++;
      @(negedge clk);
      if (py != 0 && py_n == 0) py_n = n;
    end while (!irq_valid && n < 10);
    chk("py_latency", py_n, LAT - 1);
    chk("valid_latency", n, LAT);
    chk("single_idx", irq_idx, 3);
    serve(3);
    @(negedge clk);
    chk("single_py_clr", py, 8'h00);
    chk("single_idle", irq_valid, 0);
    irq_in = 8'h00; tick(3);

    // Priority: highest line first, next winner one clock after return to idle
    irq_in = 8'h81;
    wait_valid(n);
    chk("prio_first", irq_idx, 8);
    serve(8);
    wait_valid(n);
    chk("prio_next_lat", n, 1);
    chk("prio_second", irq_idx, 1);
    serve(1);
    irq_in = 8'h00; tick(3);

    // Mask hides the line but it still latches
    mask = 8'h10; irq_in = 8'h10; tick(LAT + 1);
    @(negedge clk);
    chk("mask_py", py, 8'h00);
    chk("mask_valid", irq_valid, 0);
    mask = 8'h00; tick(1);
    @(negedge clk);
    chk("unmask_py", py, 8'h10);
    chk("unmask_idx", irq_idx, 5);
    serve(5);
    irq_in = 8'h00; tick(3);

    // Overflow and clear
    mask = 8'hff;
    irq_in = 8'h02; tick(LAT + 1);
    irq_in = 8'h00; tick(2);
    irq_in = 8'h02; tick(LAT + 1);
    @(negedge clk);
    chk("ovf_set", overflow, 8'h02);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", overflow, 8'h00);

    // Edge and ack on the same bit in the same clock
    irq_in = 8'h00; tick(2);
    irq_in = 8'h02; tick(LAT - 2);
    ack_valid = 1'b1; ack_idx = IW'(2); tick(1); ack_valid = 1'b0; ack_idx = '0;
    @(negedge clk);
    chk("collide_ovf", overflow, 8'h00);
    mask = 8'h00; tick(0);
    @(negedge clk);
    chk("collide_pend", py, 8'h02);

    // Reset during REQ
    tick(1);
    @(negedge clk);
    chk("midop_req", irq_valid, 1);
    rst = 1'b1; irq_in = 8'h00; tick(1);
    @(negedge clk);
    chk("midop_valid", irq_valid, 0);
    chk("midop_py", py, 8'h00);
    rst = 1'b0; tick(2);

    // Randomised traffic, checked every cycle by the compare process
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      if ($urandom_range(0, 15) == 0) mask = W'($urandom);
      irq_ready = ($urandom_range(0, 2) == 0);
      ack_valid = ($urandom_range(0, 3) == 0);
      ack_idx   = $urandom_range(0, 1) ? IW'(m_idx) : IW'($urandom_range(0, 15));
      ovf_clr   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    rst = 1'b0; irq_ready = 1'b0; ack_valid = 1'b0; ovf_clr = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
